// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: frame-based command decoder sitting behind an SPI slave.
// The first byte of a frame is a command (bit7 = read, low bits = start
// address). Write frames turn each following byte into a register write.
// Read frames return register contents on tx_data. Frames are delimited by
// the SSEL pin, which is synchronised here.
//
// Handshake: rx_rdy is a one-cycle qualifier for rx_data with no back-pressure.
// Each byte presented with rx_rdy is consumed in that cycle.
module spi_cmd_ctrl #(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [7:0]        tx_data,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;

  state_t              state_q, state_d;
  logic                ssel_m_q, ssel_s_q, ssel_p_q;
  logic [1:0]          vld_q, vld_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;
  logic [7:0]          tx_q, tx_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                frame_start, frame_end, rsv_set;

  // Frames only start after SSEL has been seen high following reset.
  // vld_q marks when ssel_s_q holds a real pin sample rather than a reset value.
  always_comb begin
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q | (vld_q[1] & ssel_s_q);
    busy_d      = armed_q & ~ssel_s_q;
    frame_start = armed_q & ssel_p_q & ~ssel_s_q;
    frame_end   = ~ssel_p_q & ssel_s_q;
    rsv_set     = ((rx_data[6:0] >> ADDR_W) != 7'd0);
  end

  // Command decode and register bus sequencing. Frame end overrides everything.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (frame_end) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_d = CMD;
            tx_d    = SYNC_BYTE;
            err_d   = 1'b0;
          end
        end
        CMD: begin
          if (rx_rdy) begin
            if (rsv_set) begin
              state_d = ERR;
              err_d   = 1'b1;
              tx_d    = 8'hFF;
            end else begin
              addr_d = rx_data[ADDR_W-1:0];
              if (rx_data[7]) begin
                state_d = READ;
                re_d    = 1'b1;
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        WRITE: begin
          // Address advances in the cycle after each write strobe.
          if (we_q) addr_d = addr_q + ADDR_W'(1);
          if (rx_rdy) begin
            we_d    = 1'b1;
            wdata_d = rx_data;
          end
        end
        READ: begin
          // Read data is captured while the strobe is high.
          if (re_q) tx_d = reg_rdata;
          if (rx_rdy) begin
            addr_d = addr_q + ADDR_W'(1);
            re_d   = 1'b1;
          end
        end
        ERR: begin
          tx_d = 8'hFF;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All state, the SSEL synchroniser and the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ssel_m_q <= 1'b1;
      ssel_s_q <= 1'b1;
      ssel_p_q <= 1'b1;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ssel_m_q <= ssel;
      ssel_s_q <= ssel_m_q;
      ssel_p_q <= ssel_s_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign tx_data   = tx_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: drives SPI-like frames and keeps a register-file
// model. Expected bus strobes are queued when bytes are driven and compared
// as the DUT issues them.
module tb_spi_cmd_ctrl;
  localparam int W = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       ssel;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       reg_we;
  logic       reg_re;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       cmd_err;

  logic [7:0]   regs [16];
  logic [W-1:0] exp_q[$];
  int           n_chk = 0;
  int           n_err = 0;

  spi_cmd_ctrl #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .ssel(ssel), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register file model
  assign reg_rdata = regs[reg_addr];
  always @(posedge clk) if (reg_we) regs[reg_addr] = reg_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every strobe against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] act;
    if (reg_we && reg_re) check("we_re_excl", 1, 0);
    if (reg_we || reg_re) begin
      act = {reg_we, reg_re, reg_addr, (reg_we ? reg_wdata : 8'h00)};
      if (exp_q.size() == 0) check("unexp_strobe", {18'd0, act}, 0);
      else check("bus", {18'd0, act}, {18'd0, exp_q.pop_front()});
    end
  end

  function automatic void push_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, 1'b0, a, d});
  endfunction

  function automatic void push_rd(input logic [3:0] a);
    exp_q.push_back({1'b0, 1'b1, a, 8'h00});
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_begin();
    @(posedge clk); #1 ssel = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk); #1 ssel = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[4'hE] = 8'h5A;
    regs[4'hF] = 8'h6B;
    regs[4'h0] = 8'h7C;
    regs[4'h2] = 8'h3C;
    regs[4'h7] = 8'h42;
    rst = 1'b0; ssel = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {24'd0, tx_data}, 0);
    check("rst_strobes", {30'd0, reg_we, reg_re}, 0);
    check("rst_addr", {28'd0, reg_addr}, 0);
    check("rst_wdata", {24'd0, reg_wdata}, 0);
    check("rst_busy_err", {30'd0, busy, cmd_err}, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // write burst
    frame_begin();
    check("wr_busy", {31'd0, busy}, 1);
    check("wr_sync", {24'd0, tx_data}, 32'hA5);
    push_wr(4'h3, 8'h11);
    push_wr(4'h4, 8'h22);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    frame_end();
    check("wr_err", {31'd0, cmd_err}, 0);
    check("wr_idle_busy", {31'd0, busy}, 0);

    // read burst with address wrap
    frame_begin();
    check("rd_sync", {24'd0, tx_data}, 32'hA5);
    push_rd(4'hE); push_rd(4'hF); push_rd(4'h0);
    send_byte(8'h8E); check("rd_tx0", {24'd0, tx_data}, 32'h5A);
    send_byte(8'h00); check("rd_tx1", {24'd0, tx_data}, 32'h6B);
    send_byte(8'h00); check("rd_tx2", {24'd0, tx_data}, 32'h7C);
    frame_end();
    check("rd_hold_tx", {24'd0, tx_data}, 32'h7C);

    // reserved bit error, then recovery
    frame_begin();
    send_byte(8'h40);
    check("rsv_err", {31'd0, cmd_err}, 1);
    check("rsv_tx", {24'd0, tx_data}, 32'hFF);
    send_byte(8'h99);
    check("rsv_tx2", {24'd0, tx_data}, 32'hFF);
    frame_end();
    check("rsv_err_hold", {31'd0, cmd_err}, 1);
    frame_begin();
    check("rsv_err_clr", {31'd0, cmd_err}, 0);
    push_wr(4'h1, 8'h33);
    send_byte(8'h01); send_byte(8'h33);
    frame_end();

    // SSEL rises mid-burst; next frame's first byte is a command
    frame_begin();
    push_wr(4'h5, 8'hAA);
    send_byte(8'h05); send_byte(8'hAA);
    frame_end();
    frame_begin();
    push_rd(4'h5);
    send_byte(8'h85);
    check("resync_tx", {24'd0, tx_data}, 32'hAA);
    frame_end();

    // rx_rdy in the same cycle the synchronised SSEL rises
    frame_begin();
    send_byte(8'h02);
    @(posedge clk); #1 ssel = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rx_data = 8'h77; rx_rdy = 1'b1;
    @(posedge clk); #1 rx_rdy = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("coinc_busy", {31'd0, busy}, 0);
    frame_begin();
    push_rd(4'h2);
    send_byte(8'h82);
    check("coinc_idle_rd", {24'd0, tx_data}, 32'h3C);
    frame_end();
    check("coinc_no_write", {24'd0, regs[2]}, 32'h3C);

    // reset mid-read with SSEL held low
    frame_begin();
    push_rd(4'h7);
    send_byte(8'h87);
    check("mid_tx", {24'd0, tx_data}, 32'h42);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("arst_tx", {24'd0, tx_data}, 0);
    check("arst_busy_err", {30'd0, busy, cmd_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 0);
    send_byte(8'h03);
    check("post_rst_tx", {24'd0, tx_data}, 0);
    frame_end();
    frame_begin();
    check("new_frame_busy", {31'd0, busy}, 1);
    check("new_frame_sync", {24'd0, tx_data}, 32'hA5);
    push_wr(4'h3, 8'h5E);
    send_byte(8'h03); send_byte(8'h5E);
    frame_end();

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command/register-access stage directly downstream of SPI_slave. Consumes received bytes (spi_data_o / spi_rxdy) and decodes a frame-based command protocol. Drives a simple register bus and returns the next transmit byte on spi_data_i for read bursts. Frames are delimited by the SSEL pin.

Parameters:
ADDR_W, 4, register address width; bits [ADDR_W-1:0] of the command byte form the start address; ADDR_W must be 1..7.
SYNC_BYTE, 8'hA5, byte presented on tx_data while the command byte is being shifted in.

Ports:
clk  input  1  system clock; same clock as SPI_slave
rst  input  1  asynchronous, active-low reset
ssel  input  1  raw SSEL pin, active-low frame select; asynchronous to clk
rx_data  input  8  received byte from SPI_slave spi_data_o
rx_rdy  input  1  one-cycle pulse from SPI_slave spi_rxdy; rx_data is valid in the same cycle
tx_data  output  8  next byte to shift out; connects to SPI_slave spi_data_i
reg_we  output  1  one-cycle register write strobe
reg_re  output  1  one-cycle register read strobe
reg_addr  output  ADDR_W  register address
reg_wdata  output  8  register write data
reg_rdata  input  8  register read data; combinational, valid in the same cycle as reg_re
busy  output  1  a frame is active (synchronised SSEL is low)
cmd_err  output  1  sticky error flag; cleared at the next frame start

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - tx_data, reg_we, reg_re, reg_addr, reg_wdata, busy and cmd_err = 0.
  - Both SSEL synchroniser flops = 1.
- SSEL: two-flop synchroniser gives ssel_s. A frame starts on a 1->0 transition of ssel_s and ends on a 0->1 transition. busy = ~ssel_s, registered.
- Command byte format:
  - bit7 = 1: read; bit7 = 0: write.
  - bits [6:ADDR_W] are reserved and must be 0.
  - bits [ADDR_W-1:0] = start address.
- States: IDLE, CMD, WRITE, READ, ERR.
- IDLE:
  - rx_rdy is ignored.
  - On frame start: go to CMD, tx_data <= SYNC_BYTE, cmd_err <= 0.
- CMD, on rx_rdy:
  - Any reserved bit set: go to ERR, cmd_err <= 1.
  - Otherwise reg_addr <= address field.
  - Write command: go to WRITE.
  - Read command: go to READ. In the following cycle, pulse reg_re with reg_addr = start address, and load tx_data <= reg_rdata in that same cycle.
- WRITE, on each rx_rdy:
  - Next cycle: reg_we = 1, reg_wdata = rx_data, reg_addr = current address.
  - The cycle after the strobe: address increments.
- READ, on each rx_rdy (the byte that was clocked out is done, MOSI content ignored):
  - Address increments.
  - Next cycle: reg_re pulse and tx_data <= reg_rdata at the new address.
  - Latency from rx_rdy to tx_data update is 2 cycles. The SPI_slave must sample spi_data_i no earlier than 3 clk after spi_rxdy; this holds for SCK <= clk/8.
- ERR:
  - All further bytes are ignored.
  - tx_data <= 8'hFF.
  - No reg_we or reg_re in this state.
- Address arithmetic: modulo 2^ADDR_W, so it wraps from all-ones to 0 with no error.
- Frame end (ssel_s 0->1), from any state:
  - Go to IDLE.
  - Any strobe pending at this point is cancelled.
  - tx_data holds its value. cmd_err holds its value.
- rx_rdy in the same cycle as frame end: the byte is dropped, and frame end wins.
- A frame with no bytes at all gives no bus activity and no error.
- reg_we and reg_re are never high in the same cycle. Each is high for exactly 1 cycle per byte.
- A reset mid-frame aborts immediately. After reset, a new frame needs a fresh 1->0 transition on ssel_s. If SSEL is already low when reset is released, no frame starts until SSEL goes high and then low again.

Test Plan:
- Write burst: frame with bytes 0x03, 0x11, 0x22 -> reg_we pulses at addr 3 with data 0x11, then at addr 4 with data 0x22. No reg_re. cmd_err=0.
- Read burst with wrap: regs E=0x5A, F=0x6B, 0=0x7C; frame with bytes 0x8E, x, x -> tx_data sequence A5, 5A, 6B, 7C. reg_re pulses at addr E, F, 0.
- Reserved bit: frame with bytes 0x40, 0x99 -> cmd_err=1, tx_data=FF, no strobes. Next frame with 0x01, 0x33 -> cmd_err cleared, one write of 0x33 to addr 1.
- SSEL rises mid-burst after 0x05, 0xAA, then a new frame with 0x85 -> first frame writes only addr 5. The second frame is decoded as a read of addr 5 (tx_data=0xAA), not as data.
- rx_rdy coincident with frame end -> no reg_we for that byte. State returns to IDLE.
- rst pulled low mid-read with SSEL held low -> all outputs 0 immediately. After release, no activity until SSEL goes high and then low, which starts a new frame.
